// File: rtl/dma_pkg.sv
// Shared DMA definitions: master FSM state encoding and bus word size,
// used by both the read and write masters.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_PUSH      = 3'd3,
    ST_DONE      = 3'd4
  } dma_state_e;

  localparam int unsigned WORD_BYTES = 4;

  // Byte count rounded down to whole 32-bit words.
  function automatic logic [31:0] word_trunc(input logic [31:0] len);
    return {len[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/read_master.sv
// Avalon-MM read master: one outstanding single-word read at a time,
// each returned word pushed into a downstream FIFO.
module read_master
  import dma_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_STEP = WORD_BYTES
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              Start,
  input  logic [31:0]       Length,
  input  logic [31:0]       RM_startaddress,
  output logic              oRM_read,
  output logic [31:0]       oRM_readaddress,
  input  logic              iRM_waitrequest,
  input  logic [DATA_W-1:0] iRM_readdata,
  input  logic              iRM_readdatavalid,
  input  logic              FF_full,
  output logic              FF_writerequest,
  output logic [DATA_W-1:0] FF_data,
  output logic              RM_done
);

  localparam logic [31:0] STEP = 32'(ADDR_STEP);

  dma_state_e        state_q;
  logic [31:0]       remaining_q;
  logic [31:0]       addr_q;
  logic              start_q;
  logic              read_q;
  logic              wr_q;
  logic              done_q;
  logic [DATA_W-1:0] data_q;
  logic              start_edge;

  assign start_edge = Start & ~start_q;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      addr_q      <= '0;
      start_q     <= 1'b0;
      read_q      <= 1'b0;
      wr_q        <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      start_q <= Start;
      wr_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Start edges only count here; RM_done holds until a new request.
          if (start_edge) begin
            addr_q      <= RM_startaddress;
            remaining_q <= word_trunc(Length);
            done_q      <= 1'b0;
            state_q     <= (word_trunc(Length) == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // FIFO space gates only the launch; a stalled command is never withdrawn.
          if (!read_q) begin
            if (!FF_full) read_q <= 1'b1;
          end else if (!iRM_waitrequest) begin
            read_q  <= 1'b0;
            state_q <= ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          if (iRM_readdatavalid) begin
            data_q  <= iRM_readdata;
            wr_q    <= 1'b1;
            state_q <= ST_PUSH;
          end
        end
        ST_PUSH: begin
          addr_q      <= addr_q + STEP;
          remaining_q <= remaining_q - STEP;
          state_q     <= (remaining_q <= STEP) ? ST_DONE : ST_ISSUE;
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign oRM_read        = read_q;
  assign oRM_readaddress = addr_q;
  assign FF_writerequest = wr_q;
  assign FF_data         = data_q;
  assign RM_done         = done_q;

endmodule

// File: tb/tb_read_master.sv
// Bench for read_master: Avalon slave + FIFO scoreboard, directed and
// randomized transfers checked against address/data lists built from byte counts.
module tb_read_master;

  logic        iClk = 1'b0;
  logic        iReset_n;
  logic        Start;
  logic [31:0] Length;
  logic [31:0] RM_startaddress;
  logic        oRM_read;
  logic [31:0] oRM_readaddress;
  logic        iRM_waitrequest;
  logic [31:0] iRM_readdata;
  logic        iRM_readdatavalid;
  logic        FF_full;
  logic        FF_writerequest;
  logic [31:0] FF_data;
  logic        RM_done;

  read_master #(.DATA_W(32), .ADDR_STEP(4)) dut (
    .iClk(iClk), .iReset_n(iReset_n), .Start(Start), .Length(Length),
    .RM_startaddress(RM_startaddress), .oRM_read(oRM_read),
    .oRM_readaddress(oRM_readaddress), .iRM_waitrequest(iRM_waitrequest),
    .iRM_readdata(iRM_readdata), .iRM_readdatavalid(iRM_readdatavalid),
    .FF_full(FF_full), .FF_writerequest(FF_writerequest), .FF_data(FF_data),
    .RM_done(RM_done)
  );

  initial forever #5 iClk = ~iClk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int stall_left = 0;
  int stall_cnt = 0;
  bit rand_stall = 0;
  bit spurious = 0;
  bit slave_off = 0;

  logic [31:0] obs_addr[$];
  logic [31:0] obs_push[$];
  logic [31:0] sd_q[$];
  int          push_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Main stimulus acts at posedge+3, monitor at negedge, slave at posedge+1.
  task automatic step();
    @(posedge iClk);
    #3;
  endtask

  // Slave + monitor: answers each accepted command one cycle later.
  initial begin
    bit          acc;
    bit          prev_stall;
    logic [31:0] prev_addr;
    logic [31:0] d;
    prev_stall = 0;
    prev_addr  = '0;
    forever begin
      @(negedge iClk);
      cyc++;
      acc = oRM_read && !iRM_waitrequest;
      if (acc) obs_addr.push_back(oRM_readaddress);
      if (FF_writerequest) begin
        obs_push.push_back(FF_data);
        push_cyc.push_back(cyc);
      end
      if (oRM_read && iRM_waitrequest) stall_cnt++;
      if (prev_stall) begin
        chk("stall_hold_read", {63'd0, oRM_read}, 64'd1);
        chk("stall_hold_addr", {32'd0, oRM_readaddress}, {32'd0, prev_addr});
      end
      prev_stall = oRM_read && iRM_waitrequest;
      prev_addr  = oRM_readaddress;
      @(posedge iClk);
      #1;
      if (!slave_off) begin
        if (acc) begin
          d = $urandom;
          sd_q.push_back(d);
          iRM_readdata      = d;
          iRM_readdatavalid = 1'b1;
        end else if (spurious && $urandom_range(0, 3) == 0) begin
          iRM_readdata      = $urandom;
          iRM_readdatavalid = 1'b1;
        end else begin
          iRM_readdatavalid = 1'b0;
        end
        if (oRM_read && stall_left > 0) begin
          iRM_waitrequest = 1'b1;
          stall_left--;
        end else begin
          iRM_waitrequest = 1'b0;
        end
        if (!oRM_read && rand_stall) stall_left = $urandom_range(0, 2);
      end
    end
  end

  // mode 0: quiet, 1: random FIFO-full/Start noise, 2: FIFO-full poke during stall,
  // 3: FIFO-full held for 5 cycles after first push.
  task automatic run_xfer(input string tag, input logic [31:0] a, input logic [31:0] len,
                          input int mode, output int lat);
    int          words;
    int          n;
    int          fcnt;
    bit          fdone;
    logic [31:0] e;
    words = int'(len >> 2);
    fcnt  = 0;
    fdone = 0;
    step();
    obs_addr.delete(); obs_push.delete(); sd_q.delete(); push_cyc.delete();
    stall_cnt       = 0;
    RM_startaddress = a;
    Length          = len;
    Start           = 1'b1;
    step();
    Start           = 1'b0;
    Length          = $urandom;
    RM_startaddress = $urandom;
    chk({tag, "_done_clr"}, {63'd0, RM_done}, 64'd0);
    n = 1;
    while (!RM_done && n < 3000) begin
      if (mode == 1) begin
        FF_full = ($urandom_range(0, 3) == 0);
        Start   = $urandom_range(0, 1);
      end else if (mode == 2) begin
        FF_full = oRM_read && iRM_waitrequest;
      end else if (mode == 3) begin
        if (fcnt > 0) begin
          chk({tag, "_full_noread"}, {63'd0, oRM_read}, 64'd0);
          fcnt--;
          if (fcnt == 0) FF_full = 1'b0;
        end else if (FF_writerequest && !fdone) begin
          FF_full = 1'b1;
          fcnt    = 5;
          fdone   = 1;
        end
      end
      step();
      n++;
    end
    FF_full = 1'b0;
    Start   = 1'b0;
    lat     = n;
    chk({tag, "_done"}, {63'd0, RM_done}, 64'd1);
    chk({tag, "_nreads"}, 64'(obs_addr.size()), 64'(words));
    chk({tag, "_npush"}, 64'(obs_push.size()), 64'(words));
    for (int i = 0; i < words && i < obs_addr.size(); i++) begin
      e = a + 32'(i * 4);
      chk({tag, "_addr"}, {32'd0, obs_addr[i]}, {32'd0, e});
    end
    for (int i = 0; i < obs_push.size() && i < sd_q.size(); i++)
      chk({tag, "_data"}, {32'd0, obs_push[i]}, {32'd0, sd_q[i]});
    repeat (3) step();
    chk({tag, "_done_hold"}, {63'd0, RM_done}, 64'd1);
    chk({tag, "_idle_noread"}, {63'd0, oRM_read}, 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_read"}, {63'd0, oRM_read}, 64'd0);
    chk({tag, "_addr"}, {32'd0, oRM_readaddress}, 64'd0);
    chk({tag, "_wr"}, {63'd0, FF_writerequest}, 64'd0);
    chk({tag, "_data"}, {32'd0, FF_data}, 64'd0);
    chk({tag, "_done"}, {63'd0, RM_done}, 64'd0);
  endtask

  initial begin
    int          lat;
    int          n;
    logic [31:0] a;
    logic [31:0] len;
    iReset_n          = 1'b0;
    Start             = 1'b0;
    Length            = '0;
    RM_startaddress   = '0;
    iRM_waitrequest   = 1'b0;
    iRM_readdata      = '0;
    iRM_readdatavalid = 1'b0;
    FF_full           = 1'b0;
    repeat (3) step();
    chk_reset_outputs("reset");
    iReset_n = 1'b1;
    repeat (2) step();

    // Basic 4-word transfer with a zero-wait slave: one word every 4 cycles.
    run_xfer("basic", 32'h1000, 32'd16, 0, lat);
    for (int i = 1; i < push_cyc.size(); i++)
      chk("basic_rate", 64'(push_cyc[i] - push_cyc[i-1]), 64'd4);

    // First read stalled 3 cycles; FIFO full raised during the stall.
    stall_left = 3;
    run_xfer("stall", 32'h1000, 32'd16, 2, lat);
    chk("stall_cycles", 64'(stall_cnt), 64'd3);

    run_xfer("full", 32'h0000_4000, 32'd16, 3, lat);

    run_xfer("len0", 32'h1000, 32'd0, 0, lat);
    chk("len0_lat", 64'(lat <= 2), 64'd1);
    run_xfer("len3", 32'h1000, 32'd3, 0, lat);
    chk("len3_lat", 64'(lat <= 2), 64'd1);

    run_xfer("wrap", 32'hFFFF_FFFC, 32'd8, 0, lat);
    run_xfer("trunc", 32'h0000_0100, 32'd11, 0, lat);

    // Randomized transfers: random stalls, FIFO back-pressure, spurious valids,
    // Start noise and input scrambling after acceptance.
    rand_stall = 1;
    spurious   = 1;
    for (int t = 0; t < 8; t++) begin
      a   = (t == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      len = $urandom_range(0, 40);
      run_xfer("rand", a, len, 1, lat);
    end
    rand_stall = 0;
    spurious   = 0;
    stall_left = 0;

    // Reset while waiting for data; the late readdatavalid must be ignored.
    step();
    obs_addr.delete(); obs_push.delete(); sd_q.delete(); push_cyc.delete();
    RM_startaddress = 32'h2000;
    Length          = 32'd8;
    Start           = 1'b1;
    step();
    Start = 1'b0;
    n = 0;
    while (obs_addr.size() == 0 && n < 50) begin
      step();
      n++;
    end
    chk("rst_reach_wait", 64'(obs_addr.size()), 64'd1);
    iReset_n          = 1'b0;
    slave_off         = 1;
    iRM_readdatavalid = 1'b1;
    iRM_readdata      = 32'hDEAD_BEEF;
    repeat (2) step();
    chk_reset_outputs("midrst");
    iReset_n = 1'b1;
    repeat (3) begin
      step();
      chk("stale_wr", {63'd0, FF_writerequest}, 64'd0);
    end
    chk_reset_outputs("stale");
    chk("stale_npush", 64'(obs_push.size()), 64'd0);
    iRM_readdatavalid = 1'b0;
    slave_off         = 0;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/read_master.md
READ_MASTER -- requirements
Module: read_master

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data bus width in bits.
REQ-002 SHALL have parameter ADDR_STEP, default 4: byte increment per word.
REQ-003 SHALL have iClk, input, 1: clock; all state on rising edge.
REQ-004 SHALL have iReset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have Start, input, 1: transfer request; rising edge accepted in IDLE.
REQ-006 SHALL have Length, input, 32: transfer size in bytes.
REQ-007 SHALL have RM_startaddress, input, 32: first byte address, word aligned.
REQ-008 SHALL have oRM_read, output, 1: Avalon-MM read strobe.
REQ-009 SHALL have oRM_readaddress, output, 32: Avalon-MM read address.
REQ-010 SHALL have iRM_waitrequest, input, 1: slave stall.
REQ-011 SHALL have iRM_readdata, input, DATA_W: returned read data.
REQ-012 SHALL have iRM_readdatavalid, input, 1: iRM_readdata valid this cycle.
REQ-013 SHALL have FF_full, input, 1: downstream FIFO full.
REQ-014 SHALL have FF_writerequest, output, 1: FIFO push, one-cycle pulse.
REQ-015 SHALL have FF_data, output, DATA_W: FIFO write data.
REQ-016 SHALL have RM_done, output, 1: transfer complete, level.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT_DATA, PUSH, DONE; all outputs registered.
REQ-018 IDLE: on Start rising edge (registered edge detect) SHALL latch oRM_readaddress<=RM_startaddress, remaining<=Length with bits [1:0] cleared, clear RM_done; go DONE if remaining is 0, else ISSUE.
REQ-019 ISSUE: SHALL assert oRM_read only while FF_full=0; once asserted SHALL hold oRM_read and address stable while iRM_waitrequest=1.
REQ-020 ISSUE: cycle with oRM_read=1 and iRM_waitrequest=0 SHALL end the command; next cycle oRM_read=0, state WAIT_DATA.
REQ-021 At most one read outstanding; FF_full sampled only in ISSUE before oRM_read assertion, and a raised FF_full SHALL NOT drop an already asserted oRM_read.
REQ-022 WAIT_DATA: on iRM_readdatavalid=1 SHALL register FF_data<=iRM_readdata and go PUSH; waits indefinitely otherwise.
REQ-023 PUSH: FF_writerequest=1 for exactly this cycle; address+=ADDR_STEP (mod 2^32), remaining-=ADDR_STEP; next state DONE if remaining was ADDR_STEP, else ISSUE.
REQ-024 Latency: zero-wait slave, readdatavalid one cycle after command -> one word per 4 cycles.
REQ-025 DONE: RM_done<=1, go IDLE next cycle; RM_done SHALL stay 1 in IDLE until next accepted Start.
REQ-026 Start edges outside IDLE SHALL be ignored; Length/RM_startaddress changes after acceptance SHALL have no effect.
REQ-027 iRM_readdatavalid outside WAIT_DATA SHALL be ignored.
REQ-028 Length not a multiple of 4 SHALL be truncated to whole words; Length<4 completes with no bus reads.

Reset
REQ-029 iReset_n low SHALL force IDLE, oRM_read=0, oRM_readaddress=0, FF_writerequest=0, FF_data=0, RM_done=0, remaining=0, edge-detect register=0.
REQ-030 Reset mid-transfer SHALL abandon it; an outstanding readdatavalid after release SHALL be ignored.

Structure
REQ-031 State encoding and word-size constant (ADDR_STEP) SHALL live in shared package dma_pkg, also used by write-master logic.
REQ-032 Single flat module; no sub-module.

Verification
REQ-033 Start, Length=16, addr=0x1000, zero-wait slave, FIFO empty -> reads 0x1000,0x1004,0x1008,0x100C, four FF_writerequest pulses with slave data in order, RM_done=1.
REQ-034 waitrequest held 3 cycles on first read -> oRM_read and 0x1000 stable all 3 cycles, exactly one command.
REQ-035 FF_full=1 before second read -> oRM_read stays 0 until FF_full=0, no pushes lost or duplicated.
REQ-036 Length=0 and Length=3 -> no oRM_read, RM_done=1 within 2 cycles of Start.
REQ-037 addr=0xFFFFFFFC, Length=8 -> reads 0xFFFFFFFC then 0x00000000.
REQ-038 Reset asserted in WAIT_DATA, stale readdatavalid after release -> outputs at reset values, no FF_writerequest.
